// File: rtl/harness_serdes_frame.sv
// harness_serdes_frame: framed LANES-wide serial<->parallel bridge for test harnesses.
// Define HARNESS_PARITY_EN to append an even-parity bit to every frame and expose a sticky parity_error.
module harness_serdes_frame #(
    parameter int IN_WIDTH  = 36,
    parameter int OUT_WIDTH = 36,
    parameter int LANES     = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 test_enable,
    input  logic [LANES-1:0]     test_in,
    output logic [LANES-1:0]     test_out,
    output logic                 frame_sync,
    output logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_valid,
    input  logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sample
`ifdef HARNESS_PARITY_EN
    ,
    output logic                 parity_error
`endif
);

`ifdef HARNESS_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int IN_BITS   = IN_WIDTH + PAR;
    localparam int IN_BEATS  = (IN_BITS + LANES - 1) / LANES;
    localparam int IN_SR     = IN_BEATS * LANES;
    localparam int IN_CW     = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OUT_BITS  = OUT_WIDTH + PAR;
    localparam int OUT_BEATS = (OUT_BITS + LANES - 1) / LANES;
    localparam int OUT_SR    = OUT_BEATS * LANES;
    localparam int OUT_CW    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);

    logic [IN_CW-1:0]       r_in_beat;
    logic [IN_SR-1:0]       r_in_shift;
    logic [IN_WIDTH-1:0]    r_in_data;
    logic                   r_in_valid;
    logic [OUT_CW-1:0]      r_out_beat;
    logic [OUT_SR-1:0]      r_out_shift;
    logic                   r_frame_sync;
`ifdef HARNESS_PARITY_EN
    logic                   r_parity_error;
`endif

    logic [IN_SR+LANES-1:0] w_in_cat;
    logic [IN_SR-1:0]       w_in_frame;
    logic [IN_WIDTH-1:0]    w_in_word;
    logic                   w_in_last;
    logic                   w_in_ok;
    logic                   w_in_take;
    logic                   w_out_first;
    logic [OUT_BITS-1:0]    w_out_frame;
    logic                   w_unused;

    // Leading pad bits simply fall off the top of the shift register.
    assign w_in_cat    = {r_in_shift, test_in};
    assign w_in_frame  = w_in_cat[IN_SR-1:0];
    assign w_in_word   = w_in_frame[IN_BITS-1:PAR];
    assign w_in_last   = (r_in_beat == IN_LAST);
    assign w_in_take   = w_in_last & w_in_ok;
    assign w_out_first = (r_out_beat == '0);
    assign w_unused    = ^w_in_cat;

`ifdef HARNESS_PARITY_EN
    assign w_in_ok      = ~(^w_in_frame[IN_BITS-1:0]);
    assign w_out_frame  = {out_data, ^out_data};
    assign parity_error = r_parity_error;
`else
    assign w_in_ok      = 1'b1;
    assign w_out_frame  = out_data;
`endif

    assign test_out   = r_out_shift[OUT_SR-1 -: LANES];
    assign frame_sync = r_frame_sync;
    assign in_data    = r_in_data;
    assign in_valid   = r_in_valid;
    assign out_sample = test_enable & w_out_first & ~reset;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_beat      <= '0;
            r_in_shift     <= '0;
            r_in_data      <= '0;
            r_in_valid     <= 1'b0;
            r_out_beat     <= '0;
            r_out_shift    <= '0;
            r_frame_sync   <= 1'b0;
`ifdef HARNESS_PARITY_EN
            r_parity_error <= 1'b0;
`endif
        end else if (test_enable) begin
            r_in_shift <= w_in_frame;
            r_in_beat  <= w_in_last ? '0 : r_in_beat + IN_CW'(1);
            r_in_valid <= w_in_take;
            if (w_in_take) begin
                r_in_data <= w_in_word;
            end
`ifdef HARNESS_PARITY_EN
            if (w_in_last && !w_in_ok) begin
                r_parity_error <= 1'b1;
            end
`endif
            r_out_beat   <= (r_out_beat == OUT_LAST) ? '0 : r_out_beat + OUT_CW'(1);
            r_frame_sync <= w_out_first;
            if (w_out_first) begin
                r_out_shift <= OUT_SR'(w_out_frame);
            end else begin
                r_out_shift <= r_out_shift << LANES;
            end
        end else begin
            r_in_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_harness_serdes_frame.sv
// tb_harness_serdes_frame: bit-stream reference model plus directed literal checks for harness_serdes_frame.
// Runs two instances (8-bit and 7-bit input) with LANES=2 on shared stimulus; builds with or without HARNESS_PARITY_EN.
module tb_harness_serdes_frame;

`ifdef HARNESS_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LANES   = 2;
    localparam int OUT_NB  = 8 + PAR;
    localparam int OUT_PAD = ((OUT_NB + LANES - 1) / LANES) * LANES - OUT_NB;

    logic       clock = 1'b0;
    logic       cur_rst = 1'b1;
    logic       cur_en = 1'b0;
    logic [1:0] cur_tin = '0;
    logic [7:0] cur_od = '0;

    logic [1:0] to8, to7;
    logic       fs8, fs7, iv8, iv7, os8, os7;
    logic [7:0] id8;
    logic [6:0] id7;
`ifdef HARNESS_PARITY_EN
    logic       pe8, pe7;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state: every bit received since reset, and the bits still to send.
    bit         in_stream[$];
    bit         out_q[$];
    logic [7:0] exp_data  [2];
    logic       exp_valid [2];
    logic       exp_perr  [2];
    logic [1:0] exp_to;
    logic       exp_fs;

    always #5 clock = ~clock;

    harness_serdes_frame #(.IN_WIDTH(8), .OUT_WIDTH(8), .LANES(2)) u_dut8 (
        .clock(clock), .reset(cur_rst), .test_enable(cur_en), .test_in(cur_tin),
        .test_out(to8), .frame_sync(fs8), .in_data(id8), .in_valid(iv8),
        .out_data(cur_od), .out_sample(os8)
`ifdef HARNESS_PARITY_EN
        , .parity_error(pe8)
`endif
    );

    harness_serdes_frame #(.IN_WIDTH(7), .OUT_WIDTH(8), .LANES(2)) u_dut7 (
        .clock(clock), .reset(cur_rst), .test_enable(cur_en), .test_in(cur_tin),
        .test_out(to7), .frame_sync(fs7), .in_data(id7), .in_valid(iv7),
        .out_data(cur_od), .out_sample(os7)
`ifdef HARNESS_PARITY_EN
        , .parity_error(pe7)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] tail_word(input int nbits);
        logic [63:0] w = '0;
        for (int i = in_stream.size() - nbits; i < in_stream.size(); i++) begin
            w = {w[62:0], in_stream[i]};
        end
        return w;
    endfunction

    task automatic model_step();
        if (cur_rst) begin
            in_stream.delete();
            out_q.delete();
            for (int i = 0; i < 2; i++) begin
                exp_data[i] = '0; exp_valid[i] = 1'b0; exp_perr[i] = 1'b0;
            end
            exp_to = '0;
            exp_fs = 1'b0;
        end else if (cur_en) begin
            for (int l = LANES - 1; l >= 0; l--) in_stream.push_back(cur_tin[l]);
            for (int i = 0; i < 2; i++) begin
                int nb, fb;
                logic [63:0] w;
                nb = ((i == 0) ? 8 : 7) + PAR;
                fb = ((nb + LANES - 1) / LANES) * LANES;
                exp_valid[i] = 1'b0;
                if (in_stream.size() % fb == 0) begin
                    w = tail_word(nb);
                    if (PAR == 1 && (^w) == 1'b1) begin
                        exp_perr[i] = 1'b1;
                    end else begin
                        exp_data[i]  = 8'(w >> PAR);
                        exp_valid[i] = 1'b1;
                    end
                end
            end
            exp_fs = (out_q.size() == 0);
            if (exp_fs) begin
                for (int p = 0; p < OUT_PAD; p++) out_q.push_back(1'b0);
                for (int b = 7; b >= 0; b--) out_q.push_back(cur_od[b]);
                if (PAR == 1) out_q.push_back(^cur_od);
            end
            for (int l = LANES - 1; l >= 0; l--) exp_to[l] = out_q.pop_front();
        end else begin
            exp_valid[0] = 1'b0;
            exp_valid[1] = 1'b0;
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model, settle 2 time units past the edge.
    task automatic cycle(input logic r, input logic en, input logic [1:0] tin, input logic [7:0] od);
        cur_rst = r; cur_en = en; cur_tin = tin; cur_od = od;
        @(posedge clock);
        model_step();
        #2;
    endtask

    task automatic beat(input logic [1:0] tin);
        cycle(1'b0, 1'b1, tin, cur_od);
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("in_data8", id8, exp_data[0]);
            check("in_valid8", iv8, exp_valid[0]);
            check("in_data7", id7, exp_data[1][6:0]);
            check("in_valid7", iv7, exp_valid[1]);
            check("test_out8", to8, exp_to);
            check("test_out7", to7, exp_to);
            check("frame_sync8", fs8, exp_fs);
            check("frame_sync7", fs7, exp_fs);
            check("out_sample8", os8, cur_en & ~cur_rst & (out_q.size() == 0));
            check("out_sample7", os7, cur_en & ~cur_rst & (out_q.size() == 0));
`ifdef HARNESS_PARITY_EN
            check("parity_error8", pe8, exp_perr[0]);
            check("parity_error7", pe7, exp_perr[1]);
`endif
        end
    end

    initial begin
        cycle(1'b1, 1'b0, 2'b00, 8'hA5);
        chk_en = 1'b1;
        check("rst in_data", id8, 8'h00);
        check("rst in_valid", iv8, 1'b0);
        check("rst test_out", to8, 2'b00);
        check("rst frame_sync", fs8, 1'b0);
        check("rst out_sample", os8, 1'b0);

`ifndef HARNESS_PARITY_EN
        // Frame D2 in while A5 goes out.
        beat(2'b11); check("t2 beat0", to8, 2'b10); check("t2 fs0", fs8, 1'b1);
        beat(2'b01); check("t2 beat1", to8, 2'b10); check("t2 fs1", fs8, 1'b0);
        beat(2'b00); check("t2 beat2", to8, 2'b01);
        beat(2'b10); check("t2 beat3", to8, 2'b01);
        check("t1 in_data", id8, 8'hD2); check("t1 in_valid", iv8, 1'b1);
        cycle(1'b0, 1'b0, 2'b00, 8'hA5);
        check("t1 valid drop", iv8, 1'b0); check("t1 held", id8, 8'hD2);

        // Pause mid-frame.
        cycle(1'b1, 1'b0, 2'b00, 8'h3C);
        beat(2'b11); beat(2'b01);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 2'($urandom), 8'h3C);
            check("t3 pause valid", iv8, 1'b0);
            check("t3 pause data", id8, 8'h00);
            check("t3 pause hold", to8, 2'b11);
        end
        beat(2'b00); beat(2'b10);
        check("t3 in_data", id8, 8'hD2); check("t3 in_valid", iv8, 1'b1);

        // Reset mid-frame.
        cycle(1'b1, 1'b0, 2'b00, 8'h00);
        beat(2'b11); beat(2'b01); beat(2'b00); beat(2'b10);
        beat(2'b11); beat(2'b01); beat(2'b00);
        cycle(1'b1, 1'b1, 2'b10, 8'h00);
        check("t4 rst data", id8, 8'h00); check("t4 rst valid", iv8, 1'b0);
        beat(2'b00); beat(2'b00); beat(2'b11); beat(2'b11);
        check("t4 in_data", id8, 8'h0F); check("t4 in_valid", iv8, 1'b1);

        // 7-bit word drops the first bit shifted in.
        cycle(1'b1, 1'b0, 2'b00, 8'h00);
        beat(2'b11); beat(2'b11); beat(2'b11); beat(2'b10);
        check("t5 in_data7", id7, 7'h7E); check("t5 in_valid7", iv7, 1'b1);
`else
        // 8'h01 with parity 0 over 5 beats: pad, 0000_0001, 0.
        beat(2'b00); beat(2'b00); beat(2'b00); beat(2'b00); beat(2'b10);
        check("t6 parity_error", pe8, 1'b1);
        check("t6 in_valid", iv8, 1'b0);
        check("t6 in_data", id8, 8'h00);
`endif

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
